// File: rtl/simple_inout_pkg.sv
// Shared widths and types for the 256 x 18 tri-state bus memory.
package simple_inout_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 18;
   localparam int DEPTH  = 2 ** ADDR_W;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/simple_inout_ram.sv
// DEPTH x DATA_W storage: async clear, sync write, registered read.
module simple_inout_ram
   import simple_inout_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   output logic [DATA_W-1:0] rdata
);

   data_t mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         rdata <= '0;
      end else begin
         if (we) begin
            mem[addr] <= wdata;
         end
         if (re) begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/simple_inout_mem.sv
// Single-port RAM on a shared bidirectional bus; drives the bus only
// for a read issued on the previous edge while the read is still held.
module simple_inout_mem
   import simple_inout_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] address,
   input  logic              MEM_RW,
   input  logic              MEM_OE,
   inout  wire  [DATA_W-1:0] MEM_DATA_bidir
);

   logic  rd_req;
   logic  drive_en_q;
   data_t rd_data_q;

   assign rd_req = MEM_OE & ~MEM_RW;

   simple_inout_ram u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (MEM_RW),
      .addr  (address),
      .wdata (MEM_DATA_bidir),
      .re    (rd_req),
      .rdata (rd_data_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drive_en_q <= 1'b0;
      end else begin
         drive_en_q <= rd_req;
      end
   end

   // Release is combinational so a master starting a write never contends.
   assign MEM_DATA_bidir = (drive_en_q & rd_req) ? rd_data_q : 'z;

endmodule

// File: tb/tb_simple_inout_mem.sv
// Bench for simple_inout_mem; the bus is tri1 so an idle bus reads all ones.
module tb_simple_inout_mem;
   import simple_inout_pkg::*;

   localparam data_t HIZ = '1;

   logic        clk = 1'b0;
   logic        rst_n;
   addr_t       address;
   logic        rw;
   logic        oe;
   logic        m_en;
   data_t       m_data;
   tri1 [DATA_W-1:0] bus;

   int pass_cnt = 0;
   int total    = 0;

   data_t exp_q[$];

   assign bus = m_en ? m_data : 'z;

   always #5 clk = ~clk;

   simple_inout_mem dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .address        (address),
      .MEM_RW         (rw),
      .MEM_OE         (oe),
      .MEM_DATA_bidir (bus)
   );

   typedef struct {
      logic  rw;
      logic  oe;
      addr_t addr;
      data_t wdata;
      data_t exp;
   } vec_t;

   task automatic check(input string name, input data_t act, input data_t exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: bus=%h required=%h", name, act, exp);
   endtask

   task automatic drive(input logic w, input logic e, input addr_t a,
                        input data_t d);
      rw      = w;
      oe      = e;
      address = a;
      m_en    = w;
      m_data  = d;
   endtask

   // Apply one cycle: expectation queued at drive, popped after the edge.
   task automatic step(input string name, input logic w, input logic e,
                       input addr_t a, input data_t d, input data_t exp);
      data_t x;
      drive(w, e, a, d);
      exp_q.push_back(exp);
      @(posedge clk);
      @(negedge clk);
      if (exp_q.size() == 0) begin
         total++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         x = exp_q.pop_front();
         check(name, bus, x);
      end
   endtask

   vec_t vecs[$];

   initial begin
      vecs = '{
         '{1'b0, 1'b1, 8'h00, 18'h0,     18'h00000},
         '{1'b1, 1'b0, 8'h10, 18'h2A5A5, 18'h2A5A5},
         '{1'b0, 1'b1, 8'h10, 18'h0,     18'h2A5A5},
         '{1'b1, 1'b1, 8'h01, 18'h00001, 18'h00001},
         '{1'b1, 1'b0, 8'hFF, 18'h3FFFF, 18'h3FFFF},
         '{1'b0, 1'b1, 8'h01, 18'h0,     18'h00001},
         '{1'b0, 1'b1, 8'hFF, 18'h0,     18'h3FFFF},
         '{1'b0, 1'b1, 8'h10, 18'h0,     18'h2A5A5},
         '{1'b0, 1'b0, 8'h10, 18'h0,     HIZ},
         '{1'b0, 1'b1, 8'h55, 18'h0,     18'h00000},
         '{1'b1, 1'b0, 8'h55, 18'h12345, 18'h12345},
         '{1'b0, 1'b1, 8'h55, 18'h0,     18'h12345},
         '{1'b1, 1'b0, 8'h00, 18'h00F0F, 18'h00F0F},
         '{1'b0, 1'b1, 8'h00, 18'h0,     18'h00F0F}
      };

      rst_n = 1'b0;
      drive(1'b0, 1'b0, '0, '0);
      #12;
      check("reset_idle", bus, HIZ);
      oe = 1'b1;
      #1;
      check("reset_oe_no_drive", bus, HIZ);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         step($sformatf("vec%0d", i), vecs[i].rw, vecs[i].oe,
              vecs[i].addr, vecs[i].wdata, vecs[i].exp);
      end

      // Combinational release on OE drop and on RW rise.
      step("rel_read", 1'b0, 1'b1, 8'h10, '0, 18'h2A5A5);
      oe = 1'b0;
      #1;
      check("rel_oe_drop", bus, HIZ);
      oe = 1'b1;
      #1;
      check("rel_oe_back", bus, 18'h2A5A5);
      rw = 1'b1;
      #1;
      check("rel_rw_rise", bus, HIZ);

      // Write cycle with OE high and nobody driving: DUT must stay off.
      step("pre_read", 1'b0, 1'b1, 8'h10, '0, 18'h2A5A5);
      rw      = 1'b1;
      address = 8'h20;
      #1;
      check("wr_oe_comb", bus, HIZ);
      exp_q.push_back(HIZ);
      @(posedge clk);
      @(negedge clk);
      check("wr_oe_edge", bus, exp_q.pop_front());
      step("wr_oe_readback", 1'b0, 1'b1, 8'h20, '0, HIZ);

      // Reset during an active read.
      step("mid_read", 1'b0, 1'b1, 8'h01, '0, 18'h00001);
      rst_n = 1'b0;
      #1;
      check("mid_rst_hiz", bus, HIZ);
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst_01", 1'b0, 1'b1, 8'h01, '0, 18'h00000);
      step("post_rst_10", 1'b0, 1'b1, 8'h10, '0, 18'h00000);

      if (exp_q.size() != 0) begin
         total++;
         $display("FAIL scoreboard_drain: left=%0d required=0", exp_q.size());
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
